serial_subtractor_core: RTL and testbench
=========================================

Name: serial_subtractor_core

Overview:
- Bit-serial WIDTH-bit subtractor: computes diff_out = in_a - in_b, LSB first, one bit per clock.
- Uses a combinational full-subtractor slice plus a registered borrow.
- Sits beside the combinational adder path in the three-bit ALU as the subtract/compare engine.
- Start/busy/done handshake with the ALU control.

Parameters:
- WIDTH, 3, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- in_a  input  WIDTH  minuend; latched when start is accepted.
- in_b  input  WIDTH  subtrahend; latched when start is accepted.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- diff_out  output  WIDTH  registered difference, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 means in_a < in_b (unsigned).

Behaviour:
- Reset: one clk edge with rst=1 gives state=IDLE, busy=0, done=0, diff_out=0, borrow_out=0, internal shift registers=0, borrow register=0, bit counter=0. rst overrides every other input.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - Latch in_a and in_b into shift registers.
  - Clear borrow register and counter.
  - Go to SHIFT.
- IDLE, start=0: stay; outputs hold their last result.
- SHIFT, edges E1..E(WIDTH):
  - Slice inputs: a_bit = LSB of A register, b_bit = LSB of B register, bin = borrow register.
  - Slice outputs: d = a_bit ^ b_bit ^ bin; bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin).
  - Shift d into the MSB of the result shift register; shift A and B right.
  - Borrow register <= bout; counter increments.
- Edge E(WIDTH):
  - Go to DONE.
  - diff_out <= complete result; borrow_out <= final bout.
- DONE: done=1 for exactly the one cycle after E(WIDTH). Next edge E(WIDTH+1): state=IDLE, done=0.
- Latency: done is high WIDTH cycles after start is sampled. Throughput: one operation per WIDTH+2 cycles.
- Handshake:
  - start while busy=1, including in DONE, is ignored. No queuing, no restart.
  - A start held high continuously produces back-to-back operations. Each starts at the first IDLE edge.
- Outputs diff_out and borrow_out are stable from E(WIDTH) until the next operation's E(WIDTH). They are not cleared at the next start.
- Boundaries:
  - a=b gives diff=0, borrow=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow=1.
  - rst during SHIFT or DONE aborts: no done pulse, outputs cleared.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf_out (1 bit). Reset value 0.
  - Registered at E(WIDTH) as the two's-complement overflow: (a_msb != b_msb) && (diff_msb != a_msb). The MSBs are captured at start.
  - Needs one extra flop per operand MSB.
- Undefined: port absent, no extra logic.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH = 3.
  - FSM state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and recovers to IDLE.
  - Counter width constant, $clog2(WIDTH+1).
- Sub-module full_subtractor_core: combinational 1-bit slice. Inputs in_a, in_b, in_c (borrow-in); outputs d_out, b_out. Instantiated once.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> busy=0, done=0, diff_out=0, borrow_out=0. With start=0, nothing changes for 10 cycles.
- Unsigned no-borrow: a=5, b=3, start pulse -> done exactly 3 cycles after the start edge, diff_out=3'b010, borrow_out=0, busy high 4 cycles.
- Borrow case: a=3, b=5 -> diff_out=3'b110, borrow_out=1. Also a=0, b=7 -> diff_out=3'b001, borrow_out=1.
- Ignored start: start a=7, b=7; pulse start with a=1, b=0 during SHIFT -> one done only, diff_out=0, borrow_out=0. Continuous start gives back-to-back done pulses 5 cycles apart.
- Reset mid-operation: rst at the second SHIFT edge -> no done pulse, diff_out=0. A fresh a=6, b=2 then gives diff_out=4.
- With SERIAL_SUB_OVF_EN: a=3'b011, b=3'b100 -> diff_out=3'b111, ovf_out=1. Then a=3'b010, b=3'b001 -> ovf_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the three-bit ALU and its serial subtract engine.
package alu_pkg;

  localparam int ALU_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sub_state_t;

  // Bit-counter width able to hold values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int ALU_CNT_W = cnt_width(ALU_WIDTH);

endpackage

// File: rtl/serial_subtractor_core_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// Optional ovf_out signal appears only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_core_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_out;

  modport master (output start, in_a, in_b,
                  input  busy, done, diff_out, borrow_out, ovf_out);
  modport slave  (input  start, in_a, in_b,
                  output busy, done, diff_out, borrow_out, ovf_out);
`else
  modport master (output start, in_a, in_b,
                  input  busy, done, diff_out, borrow_out);
  modport slave  (input  start, in_a, in_b,
                  output busy, done, diff_out, borrow_out);
`endif
endinterface

// File: rtl/full_subtractor_core.sv
// Combinational one-bit full subtractor: d = a - b - c, with borrow out.
module full_subtractor_core (
  input  logic in_a,
  input  logic in_b,
  input  logic in_c,
  output logic d_out,
  output logic b_out
);

  assign d_out = in_a ^ in_b ^ in_c;
  assign b_out = (~in_a & in_b) | (~(in_a ^ in_b) & in_c);

endmodule

// File: rtl/serial_subtractor_core.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional two's-complement overflow output enabled by SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// SHIFT | one slice evaluation per edge, WIDTH edges total
// DONE  | done pulse cycle, result valid
module serial_subtractor_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_subtractor_core_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bor_q;
  logic             d_slice;
  logic             b_slice;
  logic [WIDTH-1:0] r_next;

  full_subtractor_core u_slice (
    .in_a  (a_sr[0]),
    .in_b  (b_sr[0]),
    .in_c  (brw),
    .d_out (d_slice),
    .b_out (b_slice)
  );

  // Result fills from the top so the LSB lands at bit 0 after WIDTH shifts.
  assign r_next = {d_slice, r_sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;
  assign bus.ovf_out = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bor_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.in_a;
            b_sr   <= bus.in_b;
            brw    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= bus.in_a[WIDTH-1];
            b_msb  <= bus.in_b[WIDTH-1];
`endif
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next;
          brw  <= b_slice;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= ST_DONE;
            diff_q <= r_next;
            bor_q  <= b_slice;
            done_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
`endif
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff_out   = diff_q;
  assign bus.borrow_out = bor_q;

endmodule

// File: tb/tb_serial_subtractor_core.sv
// Directed self-checking bench for serial_subtractor_core (WIDTH=3).
// Overflow checks are included when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_core_if #(.WIDTH(3)) bus ();

  serial_subtractor_core #(.WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] exp_d, input logic exp_b);
    int n;
    int nb;
    bus.in_a  = a;
    bus.in_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n  = 0;
    nb = bus.busy ? 1 : 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
      if (bus.busy) nb++;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_diff"}, 32'(bus.diff_out), 32'(exp_d));
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(exp_b));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_len"}, 32'(nb), 32'd4);
  endtask

  initial begin
    int n;
    int ndone;
    bit changed;

    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff_out), 32'd0);
    check("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(bus.ovf_out), 32'd0);
`endif
    changed = 1'b0;
    bus.in_a = 3'd5;
    bus.in_b = 3'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy || bus.done || bus.diff_out != 3'd0 || bus.borrow_out) changed = 1'b1;
    end
    check("idle_stable", 32'(changed), 32'd0);

    // Plain and borrow cases
    run_op("op_5_3", 3'd5, 3'd3, 3'b010, 1'b0);
    run_op("op_3_5", 3'd3, 3'd5, 3'b110, 1'b1);
    run_op("op_6_6", 3'd6, 3'd6, 3'b000, 1'b0);
    run_op("op_0_7", 3'd0, 3'd7, 3'b001, 1'b1);

    // Start during SHIFT is ignored; old result held until new completion
    bus.in_a  = 3'd7;
    bus.in_b  = 3'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("hold_diff_at_start", 32'(bus.diff_out), 32'd1);
    check("hold_borrow_at_start", 32'(bus.borrow_out), 32'd1);
    tick();
    bus.in_a  = 3'd1;
    bus.in_b  = 3'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_diff", 32'(bus.diff_out), 32'd0);
    check("ign_borrow", 32'(bus.borrow_out), 32'd0);

    // Continuous start: back-to-back operations
    bus.in_a  = 3'd5;
    bus.in_b  = 3'd3;
    bus.start = 1'b1;
    n = 0;
    tick();
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_first_done", 32'(bus.done), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 20);
    check("b2b_spacing", 32'(n), 32'd5);
    check("b2b_diff", 32'(bus.diff_out), 32'd2);
    bus.start = 1'b0;
    tick();
    tick();
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Reset mid-operation aborts
    bus.in_a  = 3'd1;
    bus.in_b  = 3'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_diff", 32'(bus.diff_out), 32'd0);
    check("abort_borrow", 32'(bus.borrow_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op("op_6_2", 3'd6, 3'd2, 3'd4, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_3_4", 3'b011, 3'b100, 3'b111, 1'b1);
    check("ovf_3_4_flag", 32'(bus.ovf_out), 32'd1);
    run_op("ovf_2_1", 3'b010, 3'b001, 3'b001, 1'b0);
    check("ovf_2_1_flag", 32'(bus.ovf_out), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
